// File: rtl/aes_io_buffer.sv
// Word-serial message/key/result buffer between the bus FSM and an AES-128 core.
// Optional macro AES_IO_KEY_ZEROIZE_EN: clear the key register on every ciphertext capture.
module aes_io_buffer #(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               shift_in_message,
    input  logic               shift_in_key,
    input  logic               load,
    input  logic               shift_out,
    output logic [DATA_W-1:0]  data_out,
    output logic [BLOCK_W-1:0] aes_message,
    output logic [BLOCK_W-1:0] aes_key,
    output logic               aes_start,
    input  logic [BLOCK_W-1:0] aes_result,
    input  logic               aes_done,
    output logic               msg_full,
    output logic               key_full,
    output logic               out_valid,
    output logic               busy
);

    localparam int WORDS = BLOCK_W / DATA_W;
    localparam int CNT_W = $clog2(WORDS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [BLOCK_W-1:0] msg_reg;
    logic [BLOCK_W-1:0] key_reg;
    logic [BLOCK_W-1:0] out_reg;
    logic [CNT_W-1:0]   msg_cnt;
    logic [CNT_W-1:0]   key_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic               capture;

    assign msg_full    = (msg_cnt == CNT_FULL);
    assign key_full    = (key_cnt == CNT_FULL);
    assign out_valid   = (out_cnt != '0);
    assign data_out    = out_reg[BLOCK_W-1 -: DATA_W];
    assign aes_message = msg_reg;
    assign aes_key     = key_reg;
    assign capture     = (state == S_WAIT) && aes_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load && msg_full && key_full) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (aes_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        aes_start = (state == S_START);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_reg <= '0;
            key_reg <= '0;
            out_reg <= '0;
            msg_cnt <= '0;
            key_cnt <= '0;
            out_cnt <= '0;
        end else begin
            // Operands only move in IDLE, so they stay frozen while the core runs.
            if (state == S_IDLE) begin
                if (shift_in_message) begin
                    if (!msg_full) begin
                        msg_reg <= {msg_reg[BLOCK_W-DATA_W-1:0], data_in};
                        msg_cnt <= msg_cnt + CNT_W'(1);
                    end
                end else if (shift_in_key && !key_full) begin
                    key_reg <= {key_reg[BLOCK_W-DATA_W-1:0], data_in};
                    key_cnt <= key_cnt + CNT_W'(1);
                end
            end

            // A capture overrides a coincident pop and reloads the full result.
            if (capture) begin
                out_reg <= aes_result;
                out_cnt <= CNT_FULL;
                msg_cnt <= '0;
`ifdef AES_IO_KEY_ZEROIZE_EN
                key_reg <= '0;
                key_cnt <= '0;
`endif
            end else if (shift_out && out_valid) begin
                out_reg <= out_reg << DATA_W;
                out_cnt <= out_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_io_buffer.sv
// Directed bench for aes_io_buffer: a per-cycle vector table for the main flow
// plus hand-written sequences for reset, operand freezing and capture collisions.
module tb_aes_io_buffer;

    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] MSG  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MSG2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] RES2 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] MSG3 = 128'h55555555666666667777777788888888;
    localparam logic [127:0] RES3 = 128'haaaaaaaabbbbbbbbccccccccdddddddd;
`ifdef AES_IO_KEY_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  data_in = '0;
    logic         shift_in_message = 1'b0;
    logic         shift_in_key = 1'b0;
    logic         load = 1'b0;
    logic         shift_out = 1'b0;
    logic [31:0]  data_out;
    logic [127:0] aes_message;
    logic [127:0] aes_key;
    logic         aes_start;
    logic [127:0] aes_result = CT;
    logic         aes_done = 1'b0;
    logic         msg_full;
    logic         key_full;
    logic         out_valid;
    logic         busy;

    int errors = 0;
    int checks = 0;

    aes_io_buffer #(.DATA_W(32), .BLOCK_W(128)) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .shift_in_message(shift_in_message),
        .shift_in_key(shift_in_key),
        .load(load),
        .shift_out(shift_out),
        .data_out(data_out),
        .aes_message(aes_message),
        .aes_key(aes_key),
        .aes_start(aes_start),
        .aes_result(aes_result),
        .aes_done(aes_done),
        .msg_full(msg_full),
        .key_full(key_full),
        .out_valid(out_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sim, sik, ld, so, done;
        logic [31:0] din;
        bit          mf, kf, ov, bz, st;
        logic [31:0] dout;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit sim, input bit sik, input bit ld, input bit so,
                        input bit done, input logic [31:0] din);
        shift_in_message = sim;
        shift_in_key     = sik;
        load             = ld;
        shift_out        = so;
        aes_done         = done;
        data_in          = din;
        @(posedge clk);
        #1;
        shift_in_message = 1'b0;
        shift_in_key     = 1'b0;
        load             = 1'b0;
        shift_out        = 1'b0;
        aes_done         = 1'b0;
    endtask

    task automatic shift_block(input bit is_key, input bit both, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) begin
            step(!is_key || both, is_key || both, 1'b0, 1'b0, 1'b0, blk[127-32*i -: 32]);
        end
    endtask

    task automatic chk_status(input string tag, input bit mf, input bit kf, input bit ov,
                              input bit bz, input bit st, input logic [31:0] dout);
        chk({tag, ".msg_full"},  128'(msg_full),  128'(mf));
        chk({tag, ".key_full"},  128'(key_full),  128'(kf));
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(ov));
        chk({tag, ".busy"},      128'(busy),      128'(bz));
        chk({tag, ".aes_start"}, 128'(aes_start), 128'(st));
        chk({tag, ".data_out"},  128'(data_out),  128'(dout));
    endtask

    task automatic chk_all_zero(input string tag);
        chk_status(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk({tag, ".aes_message"}, aes_message, 128'h0);
        chk({tag, ".aes_key"},     aes_key,     128'h0);
    endtask

    initial begin
        bit ka;
        ka = !ZEROIZE;

        //          sim  sik  ld   so   done din            mf   kf   ov   bz   st   dout
        vt[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h00010203, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0};
        vt[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h04050607, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0};
        vt[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h08090a0b, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0};
        vt[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0c0d0e0f, 1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
        vt[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h00112233, 1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
        vt[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h44556677, 1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
        vt[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h8899aabb, 1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
        vt[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
        vt[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'hccddeeff, 1'b1,1'b1,1'b0,1'b0,1'b0,32'h0};
        vt[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'hdeadbeef, 1'b1,1'b1,1'b0,1'b0,1'b0,32'h0};
        vt[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b1,1'b1,32'h0};
        vt[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b1,1'b0,32'h0};
        vt[12] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h11111111, 1'b1,1'b1,1'b0,1'b1,1'b0,32'h0};
        vt[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        1'b0,ka,  1'b1,1'b0,1'b0,32'h69c4e0d8};
        vt[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,ka,  1'b1,1'b0,1'b0,32'h6a7b0430};
        vt[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,ka,  1'b1,1'b0,1'b0,32'hd8cdb780};
        vt[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,ka,  1'b1,1'b0,1'b0,32'h70b4c55a};
        vt[17] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,ka,  1'b0,1'b0,1'b0,32'h0};
        vt[18] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,ka,  1'b0,1'b0,1'b0,32'h0};
        vt[19] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        1'b0,ka,  1'b0,1'b0,1'b0,32'h0};

        // Reset state
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_all_zero("reset");
        reset = 1'b0;

        // FIPS-197 block, load guard, full-register guard, frozen operands, stray done
        for (int i = 0; i < 20; i++) begin
            step(vt[i].sim, vt[i].sik, vt[i].ld, vt[i].so, vt[i].done, vt[i].din);
            chk_status($sformatf("vec%0d", i), vt[i].mf, vt[i].kf, vt[i].ov,
                       vt[i].bz, vt[i].st, vt[i].dout);
        end
        chk("post.aes_message", aes_message, MSG);
        chk("post.aes_key", aes_key, ZEROIZE ? 128'h0 : KEY);

        // Second block: key reuse depends on zeroize
        shift_block(1'b0, 1'b0, MSG2);
        chk("blk2.key_full", 128'(key_full), 128'(!ZEROIZE));
        if (ZEROIZE) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("blk2.blocked_start", 128'(aes_start), 128'h0);
            chk("blk2.blocked_busy", 128'(busy), 128'h0);
            shift_block(1'b1, 1'b0, KEY);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("blk2.start", 128'(aes_start), 128'h1);
        chk("blk2.aes_message", aes_message, MSG2);
        chk("blk2.aes_key", aes_key, KEY);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_status("blk2.wait", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        aes_result = RES2;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk_status("blk2.cap", 1'b0, !ZEROIZE, 1'b1, 1'b0, 1'b0, 32'h11111111);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("blk2.pop1", 128'(data_out), 128'h22222222);

        // Third block captured while words remain, with a coincident pop
        shift_block(1'b0, 1'b0, MSG3);
        if (ZEROIZE) shift_block(1'b1, 1'b0, KEY);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("blk3.start", 128'(aes_start), 128'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        aes_result = RES3;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk_status("blk3.collide", 1'b0, !ZEROIZE, 1'b1, 1'b0, 1'b0, 32'haaaaaaaa);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("blk3.pop1", 128'(data_out), 128'hbbbbbbbb);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("blk3.pop2", 128'(data_out), 128'hcccccccc);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("blk3.pop3", 128'(data_out), 128'hdddddddd);
        chk("blk3.pop3_valid", 128'(out_valid), 128'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("blk3.pop4", 128'(data_out), 128'h0);
        chk("blk3.empty", 128'(out_valid), 128'h0);

        // Reset while waiting on the core, then a late done
        shift_block(1'b0, 1'b0, MSG2);
        if (ZEROIZE) shift_block(1'b1, 1'b0, KEY);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst.in_wait", 128'(busy), 128'h1);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        chk_all_zero("rst.mid");
        aes_result = CT;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk_all_zero("rst.late_done");

        // Simultaneous message+key shifts: message only
        shift_block(1'b0, 1'b1, MSG);
        chk("both.msg_full", 128'(msg_full), 128'h1);
        chk("both.key_full", 128'(key_full), 128'h0);
        chk("both.aes_message", aes_message, MSG);
        chk("both.aes_key", aes_key, 128'h0);

        // Recovery: full FIPS-197 block again
        shift_block(1'b1, 1'b0, KEY);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("rec.start", 128'(aes_start), 128'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rec.word%0d", i), 128'(data_out), 128'(CT[127-32*i -: 32]));
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        end
        chk("rec.empty_valid", 128'(out_valid), 128'h0);
        chk("rec.empty_data", 128'(data_out), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
